clb_logic_block: RTL and testbench
==================================

Name: clb_logic_block

Overview:
- Configurable logic block (CLB) for the FPGA fabric tile: one 4-input LUT with an optional output register.
- Configuration is loaded serially through a shift chain; prog_out feeds the next element in the tile's configuration chain (the switch box).
- The connection block drives clb_input through its routing muxes and fans clb_output out to the routing tracks.
- The LUT read path is built from two generic mux sub-blocks, which are reused elsewhere in the tile.

Parameters:
- CFG_BITS, 17 (localparam, not overridable), configuration chain length: 16 LUT bits + 1 output-select bit.
- LUT_INPUTS, 4 (localparam), LUT input count; LUT depth is 2^LUT_INPUTS = 16.

Ports:
- clb_clk  input  1  Single clock. Drives both configuration shifting and the user output register.
- rst_n  input  1  Reset, asynchronous and active-low.
- prog_en  input  1  Configuration shift enable.
- prog_in  input  1  Serial configuration data in.
- clb_input  input  4  LUT address inputs from the connection-block muxes.
- prog_out  output  1  Serial configuration data out; always equals cfg[0].
- clb_output  output  1  CLB result.

Behaviour:
- Clocking and reset: one clock domain (clb_clk). Reset is asynchronous and active-low.
- State: cfg[16:0] configuration register and ff, the 1-bit user register.
- Reset (rst_n=0, asynchronous): cfg=0, ff=0. This gives prog_out=0 and clb_output=0 for any input.
- Shift: on posedge clb_clk with prog_en=1, cfg <= {prog_in, cfg[16:1]}.
  - A bit presented on prog_in appears on prog_out after 17 enabled edges.
  - To load word W, shift W[0] first and W[16] last.
- Shift hold: with prog_en=0, cfg holds and prog_in is ignored.
- Bit map:
  - cfg[15:0] = LUT truth table; lut_out = cfg[clb_input].
  - cfg[16] = output select: 0 selects combinational, 1 selects registered.
- LUT path:
  - mux_8to1 lo selects over cfg[7:0] with sel=clb_input[2:0].
  - mux_8to1 hi selects over cfg[15:8] with sel=clb_input[2:0].
  - mux_2to1 selects {hi,lo} with sel=clb_input[3].
  - Purely combinational, zero latency.
- User register: on posedge clb_clk with prog_en=0, ff <= lut_out. While prog_en=1, ff holds.
- Output: clb_output = mux_2to1 over {ff, lut_out} with sel=cfg[16].
  - Combinational mode: same-cycle response.
  - Registered mode: 1-cycle latency.
- During programming, clb_output follows the partially shifted cfg (no output gating). Consumers must ignore it while prog_en=1.
- Reset mid-shift: cfg and ff clear immediately. A full 17-bit reload is required afterwards.
- Reset release: the first edge after rst_n rises is a normal edge.

Decomposition:
- Shared package tile_cfg_pkg holds:
  - CLB_CFG_BITS=17, LUT_INPUTS=4;
  - bit-index constants CFG_LUT_LSB=0, CFG_LUT_MSB=15, CFG_OUTSEL=16.
- Sub-modules:
  - mux_2to1: MUX_sel[0], MUX_in[1:0], MUX_out = MUX_in[MUX_sel].
  - mux_8to1: MUX_sel[2:0], MUX_in[7:0], MUX_out = MUX_in[MUX_sel].
  - Both are purely combinational, with no X-propagation special cases.
- Top instantiates 2x mux_8to1 + 2x mux_2to1.

Test Plan:
1. Mux units: mux_8to1 with MUX_in=8'b1010_0110, sel 0..7 -> out 0,1,1,0,0,1,0,1. mux_2to1 with MUX_in=2'b10, sel 0 -> 0, sel 1 -> 1.
2. Combinational AND4: reset, then shift W=17'h08000 (W[0] first, prog_en=1, 17 edges), then prog_en=0.
   - clb_input=4'hF -> clb_output=1 in the same cycle.
   - clb_input=4'hE -> 0.
3. Registered XOR4: load W=17'h16996, prog_en=0, drive clb_input 4'h1 then 4'h3 on successive edges.
   - clb_output=1 one edge after 4'h1 is applied.
   - clb_output=0 one edge after 4'h3 is applied.
   - clb_output does not change before the edge.
4. Chain pass-through: after reset, shift one 1 followed by zeros.
   - prog_out=0 for edges 1..16.
   - prog_out=1 after edge 17.
   - prog_out=0 after edge 18.
5. Shift hold: configured AND4, prog_en=0, toggle prog_in for 20 edges -> cfg unchanged; 4'hF still gives 1 and prog_out stays constant.
6. Async reset: assert rst_n=0 between edges while in registered mode with ff=1 and mid-shift.
   - clb_output=0 and prog_out=0 immediately.
   - Values stay 0 after release until reprogrammed.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
// Shared configuration constants for the fabric tile: CLB chain length and
// the position of each field in the CLB configuration word.
package tile_cfg_pkg;
  localparam int CLB_CFG_BITS = 17;
  localparam int LUT_INPUTS   = 4;
  localparam int CFG_LUT_LSB  = 0;
  localparam int CFG_LUT_MSB  = 15;
  localparam int CFG_OUTSEL   = 16;
endpackage

// File: rtl/mux_2to1.sv
// Generic 2:1 mux, shared by the CLB and other tile elements.
module mux_2to1 (
  input  logic       MUX_sel,
  input  logic [1:0] MUX_in,
  output logic       MUX_out
);
  assign MUX_out = MUX_in[MUX_sel];
endmodule

// File: rtl/mux_8to1.sv
// Generic 8:1 mux, shared by the CLB and other tile elements.
module mux_8to1 (
  input  logic [2:0] MUX_sel,
  input  logic [7:0] MUX_in,
  output logic       MUX_out
);
  assign MUX_out = MUX_in[MUX_sel];
endmodule

// File: rtl/clb_logic_block.sv
// Configurable logic block: serially programmed 4-input LUT with an optional
// output register. prog_out continues the tile configuration chain.
module clb_logic_block
  import tile_cfg_pkg::*;
(
  input  logic                  clb_clk,
  input  logic                  rst_n,
  input  logic                  prog_en,
  input  logic                  prog_in,
  input  logic [LUT_INPUTS-1:0] clb_input,
  output logic                  prog_out,
  output logic                  clb_output
);
  localparam int CFG_BITS = CLB_CFG_BITS;

  logic [CFG_BITS-1:0]            cfg;
  logic [CFG_LUT_MSB:CFG_LUT_LSB] lut_bits;
  logic                           ff;
  logic                           lut_lo;
  logic                           lut_hi;
  logic                           lut_out;

  // LSB exits first, so the first bit shifted in ends up in cfg[0]
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (prog_en) begin
      cfg <= {prog_in, cfg[CFG_BITS-1:1]};
    end
  end

  // The user register is frozen while the chain is being shifted
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= 1'b0;
    end else if (!prog_en) begin
      ff <= lut_out;
    end
  end

  assign lut_bits = cfg[CFG_LUT_MSB:CFG_LUT_LSB];
  assign prog_out = cfg[0];

  mux_8to1 u_mux_lo (
    .MUX_sel (clb_input[2:0]),
    .MUX_in  (lut_bits[7:0]),
    .MUX_out (lut_lo)
  );

  mux_8to1 u_mux_hi (
    .MUX_sel (clb_input[2:0]),
    .MUX_in  (lut_bits[15:8]),
    .MUX_out (lut_hi)
  );

  mux_2to1 u_mux_lut (
    .MUX_sel (clb_input[3]),
    .MUX_in  ({lut_hi, lut_lo}),
    .MUX_out (lut_out)
  );

  mux_2to1 u_mux_out (
    .MUX_sel (cfg[CFG_OUTSEL]),
    .MUX_in  ({ff, lut_out}),
    .MUX_out (clb_output)
  );
endmodule

// File: tb/tb_clb_logic_block.sv
// Self-checking bench for clb_logic_block with a queue-based reference model.
module tb_clb_logic_block;
  logic       clb_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_en = 1'b0;
  logic       prog_in = 1'b0;
  logic [3:0] clb_input = 4'h0;
  logic       prog_out;
  logic       clb_output;

  logic [2:0] t8_sel;
  logic [7:0] t8_in;
  logic       t8_out;
  logic       t2_sel;
  logic [1:0] t2_in;
  logic       t2_out;

  int checks = 0;
  int errors = 0;

  // model: the last 17 bits shifted in, oldest first; ff tracked separately
  bit hist[$];
  bit m_ff;

  clb_logic_block dut (
    .clb_clk    (clb_clk),
    .rst_n      (rst_n),
    .prog_en    (prog_en),
    .prog_in    (prog_in),
    .clb_input  (clb_input),
    .prog_out   (prog_out),
    .clb_output (clb_output)
  );

  mux_8to1 u_t8 (.MUX_sel(t8_sel), .MUX_in(t8_in), .MUX_out(t8_out));
  mux_2to1 u_t2 (.MUX_sel(t2_sel), .MUX_in(t2_in), .MUX_out(t2_out));

  always #5 clb_clk = ~clb_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < 17; i++) hist.push_back(1'b0);
    m_ff = 1'b0;
  endtask

  function automatic bit m_cfg(input int idx);
    return hist[idx];
  endfunction

  function automatic bit m_lut(input logic [3:0] a);
    return m_cfg(int'(a));
  endfunction

  function automatic bit m_out();
    return m_cfg(16) ? m_ff : m_lut(clb_input);
  endfunction

  // one clock edge: model follows the spec rules using pre-edge inputs
  task automatic tick();
    bit pe, pi, lut_pre;
    pe = prog_en;
    pi = prog_in;
    lut_pre = m_lut(clb_input);
    @(posedge clb_clk);
    if (pe) begin
      hist.push_back(pi);
      void'(hist.pop_front());
    end else begin
      m_ff = lut_pre;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out"}, clb_output, m_out());
    chk({tag, "_pout"}, prog_out, m_cfg(0));
  endtask

  task automatic load(input logic [16:0] w, input bit check_each);
    prog_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      prog_in = w[i];
      tick();
      if (check_each) check_model("shift");
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0]  mux8_pat;
    logic [7:0]  mux8_exp;
    logic [16:0] w;
    logic        pout_hold;

    m_reset();
    t8_sel = 3'd0; t8_in = 8'h00; t2_sel = 1'b0; t2_in = 2'b00;
    #12;
    chk("reset_out", clb_output, 1'b0);
    chk("reset_pout", prog_out, 1'b0);
    rst_n = 1'b1;
    #1;

    // generic mux units
    mux8_pat = 8'b1010_0110;
    mux8_exp = 8'b1010_0110;
    t8_in = mux8_pat;
    for (int s = 0; s < 8; s++) begin
      t8_sel = 3'(s);
      #1;
      chk($sformatf("mux8_sel%0d", s), t8_out, mux8_exp[s]);
    end
    t2_in = 2'b10;
    t2_sel = 1'b0; #1; chk("mux2_sel0", t2_out, 1'b0);
    t2_sel = 1'b1; #1; chk("mux2_sel1", t2_out, 1'b1);

    // combinational AND4
    load(17'h08000, 1'b0);
    clb_input = 4'hF; #1; chk("and4_F", clb_output, 1'b1);
    clb_input = 4'hE; #1; chk("and4_E", clb_output, 1'b0);

    // registered XOR4
    load(17'h16996, 1'b0);
    clb_input = 4'h1; tick();
    chk("xor_after_1", clb_output, 1'b1);
    clb_input = 4'h3; #2;
    chk("xor_before_edge", clb_output, 1'b1);
    tick();
    chk("xor_after_3", clb_output, 1'b0);

    // chain pass-through
    rst_n = 1'b0; #1; rst_n = 1'b1; m_reset();
    prog_en = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      prog_in = (e == 1);
      tick();
      chk($sformatf("chain_e%0d", e), prog_out, e == 17);
    end
    prog_en = 1'b0;

    // shift hold
    load(17'h08000, 1'b0);
    pout_hold = prog_out;
    clb_input = 4'hF;
    for (int e = 0; e < 20; e++) begin
      prog_in = ~prog_in;
      tick();
      chk("hold_pout", prog_out, pout_hold);
    end
    chk("hold_and4_F", clb_output, 1'b1);
    check_model("hold_model");

    // randomized configurations and inputs against the model
    for (int n = 0; n < 6; n++) begin
      w = 17'($urandom);
      load(w, 1'b1);
      for (int c = 0; c < 24; c++) begin
        clb_input = 4'($urandom_range(0, 15));
        #1;
        check_model("rand_pre");
        tick();
        check_model("rand_post");
      end
    end

    // async reset mid-shift with registered output high
    load(17'h16996, 1'b0);
    clb_input = 4'h1; tick();
    chk("areset_ff_set", clb_output, 1'b1);
    prog_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prog_in = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0; m_reset();
    #1;
    chk("areset_out", clb_output, 1'b0);
    chk("areset_pout", prog_out, 1'b0);
    prog_en = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      clb_input = 4'($urandom_range(0, 15));
      tick();
      chk("post_reset_out", clb_output, 1'b0);
      chk("post_reset_pout", prog_out, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
